// File: rtl/fetch_unit_if.sv
// Fetch bus bundle: BRAM instruction port plus the
// downstream instr valid/ready handshake. master = fetch side.
interface fetch_unit_if #(
  parameter int PC_WIDTH    = 16,
  parameter int INSTR_WIDTH = 32
);
  logic                   imem_en;
  logic [PC_WIDTH-3:0]    imem_addr;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic                   instr_valid;
  logic [INSTR_WIDTH-1:0] instr;
  logic [PC_WIDTH-1:0]    instr_pc;
  logic                   instr_ready;

  modport master (
    output imem_en,
    output imem_addr,
    input  imem_rdata,
    output instr_valid,
    output instr,
    output instr_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_en,
    input  imem_addr,
    output imem_rdata,
    input  instr_valid,
    input  instr,
    input  instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues BRAM word reads, buffers
// {instr,pc} in a DEPTH FIFO, hands them out over valid/ready.
// Ports: sysclk, rst (sync, active high), bus (fetch_unit_if
// master: imem_* read port, instr_* handshake), redirect,
// redirect_pc, misaligned_redirect (registered pulse).
module fetch_unit #(
  parameter int PC_WIDTH    = 16,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                sysclk,
  input  logic                rst,
  fetch_unit_if.master        bus,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                misaligned_redirect
);
  localparam int AW = $clog2(DEPTH);

  logic [PC_WIDTH-1:0]    fetch_pc;
  logic [PC_WIDTH-1:0]    inflight_pc;
  logic                   inflight;
  logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
  logic [PC_WIDTH-1:0]    pc_mem [DEPTH];
  logic [AW-1:0]          rptr;
  logic [AW-1:0]          wptr;
  logic [AW:0]            count;
  logic [AW+1:0]          credit;
  logic                   pop;
  logic                   push;
  logic                   issue;

  assign bus.instr_valid = (count != '0);
  assign bus.instr       = instr_mem[rptr];
  assign bus.instr_pc    = pc_mem[rptr];

  assign pop  = bus.instr_valid & bus.instr_ready & ~redirect;
  assign push = inflight & ~redirect;

  // Slots committed: buffered + returning - leaving this cycle.
  // Issuing only below DEPTH guarantees the next push fits.
  assign credit = {1'b0, count}
                + {{(AW+1){1'b0}}, inflight}
                - {{(AW+1){1'b0}}, pop};

  assign issue = ~rst & ~redirect
               & (credit < (AW+2)'(DEPTH));

  assign bus.imem_en   = issue;
  assign bus.imem_addr = fetch_pc[PC_WIDTH-1:2];

  always_ff @(posedge sysclk) begin
    if (push & ~rst) begin
      instr_mem[wptr] <= bus.imem_rdata;
      pc_mem[wptr]    <= inflight_pc;
    end
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      fetch_pc            <= RESET_PC;
      inflight            <= 1'b0;
      inflight_pc         <= '0;
      rptr                <= '0;
      wptr                <= '0;
      count               <= '0;
      misaligned_redirect <= 1'b0;
    end else begin
      misaligned_redirect <= redirect & (|redirect_pc[1:0]);
      if (redirect) begin
        fetch_pc <= {redirect_pc[PC_WIDTH-1:2], 2'b00};
        inflight <= 1'b0;
        rptr     <= '0;
        wptr     <= '0;
        count    <= '0;
      end else begin
        inflight <= issue;
        if (issue) begin
          inflight_pc <= fetch_pc;
          fetch_pc    <= fetch_pc + PC_WIDTH'(4);
        end
        if (push) wptr <= wptr + AW'(1);
        if (pop)  rptr <= rptr + AW'(1);
        if (push & ~pop)
          count <= count + (AW+1)'(1);
        else if (pop & ~push)
          count <= count - (AW+1)'(1);
      end
    end
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch front end that decouples PC generation from instruction consumption in the next-generation core. It drives word reads into the synchronous instruction port of the unified dual-port BRAM, buffers returned instructions with their PCs in a DEPTH-entry FIFO, and hands them downstream over a valid/ready handshake. Redirects from branches, jumps, traps, ecall/ebreak and mret flush the buffer and drop any in-flight read.

## Interface
Parameters:
- PC_WIDTH, 16, byte-address width of the PC; wraps modulo 2^PC_WIDTH.
- INSTR_WIDTH, 32, instruction word width.
- DEPTH, 4, FIFO entries; legal range 2..16, power of two.
- RESET_PC, 0, PC fetched first after reset; bits [1:0] must be 0.

Ports:
- sysclk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_en  out  1  read request this cycle.
- imem_addr  out  PC_WIDTH-2  word address, which is fetch_pc[PC_WIDTH-1:2].
- imem_rdata  in  INSTR_WIDTH  read data, valid exactly one cycle after imem_en.
- redirect  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  PC_WIDTH  new fetch address.
- instr_valid  out  1  FIFO head valid.
- instr  out  INSTR_WIDTH  FIFO head instruction.
- instr_pc  out  PC_WIDTH  PC of FIFO head.
- instr_ready  in  1  consumer accepts the head.
- misaligned_redirect  out  1  registered one-cycle pulse; redirect_pc[1:0] was nonzero.

## Operation
- State: fetch_pc, inflight bit, inflight_pc, FIFO (instr and PC per entry, read/write pointers, count 0..DEPTH).
- pop = instr_valid & instr_ready & ~redirect.
- Issue: imem_en = ~rst & ~redirect & (count + inflight - pop < DEPTH). On issue, inflight <= 1, inflight_pc <= fetch_pc, fetch_pc <= fetch_pc + 4 (mod 2^PC_WIDTH). With no issue, inflight <= 0.
- Response: if inflight was 1 in the previous cycle and no redirect occurs this cycle, push {imem_rdata, inflight_pc}. The credit rule guarantees the push never overflows.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Redirect has priority over everything:
  - count <= 0, pointers <= 0, inflight <= 0.
  - The response returning this cycle is discarded.
  - fetch_pc <= {redirect_pc[PC_WIDTH-1:2], 2'b00}, so the low bits are forced to zero.
  - A pop in the same cycle is ignored.
  - misaligned_redirect <= |redirect_pc[1:0].
- Back-to-back redirects: the last one wins. Each one restarts the latency below.
- instr and instr_pc are don't-care while instr_valid = 0.
- Outputs hold stable while instr_valid = 1 and instr_ready = 0, unless a redirect arrives.

## Timing
- Reset values: fetch_pc = RESET_PC, count = 0, inflight = 0, instr_valid = 0, misaligned_redirect = 0. imem_en = 0 during reset.
- First cycle after rst deasserts: imem_en = 1 with imem_addr = RESET_PC >> 2.
- Redirect sampled at edge E:
  - request at the new PC in the cycle after E;
  - data arrives one cycle later and is pushed at that cycle's edge;
  - instr_valid = 1 two cycles after E, i.e. the cycle after the push.
- Fetch-to-valid latency is 2 cycles. There is no bypass: the FIFO output is registered through the count.
- Sustained throughput is 1 instruction/cycle with instr_ready held at 1, for any DEPTH ≥ 2.
- Full FIFO and instr_ready = 0: imem_en = 0 and fetch_pc holds. Fetch resumes the same cycle a pop occurs.
- rst mid-operation: the next cycle matches the post-reset state exactly. The in-flight response is discarded.

## Test plan
- Reset release, instr_ready = 1, memory word n = n: instr_pc sequence is 0x0, 0x4, 0x8…; instr = 0, 1, 2…; first instr_valid 2 cycles after reset release; one instruction per cycle thereafter.
- instr_ready = 0 for 10 cycles, DEPTH = 4: count saturates at 4 and imem_en drops to 0. On release, four buffered PCs drain in order, then fetch continues with no gap and no duplicate.
- redirect to 0x100 while FIFO holds 3 entries and a read is in flight: none of the old PCs appear. instr_valid = 0 for 2 cycles, then instr_pc = 0x100, 0x104.
- redirect and instr_ready in the same cycle, plus two consecutive redirects 0x40 then 0x80: no pop is counted, and the first delivered instr_pc is 0x80.
- redirect_pc = 0x103: misaligned_redirect pulses for exactly one cycle, and fetch resumes at 0x100.
- PC_WIDTH = 8, redirect to 0xFC: instr_pc sequence is 0xFC, then 0x00, wrapping.
